ex_issue_ctrl: RTL and testbench

Issue and sequencing controller for the execute stage. It accepts one decoded operation at a time from decode over a valid/ready handshake. It drives the one-hot unit-select controls consumed by the EX result register, and holds off issue while the multi-cycle multiplier or an outstanding load is pending. It produces the writeback valid and destination tag aligned with the result the EX result register presents, and supports a pipeline flush that cancels in-flight work.

---
 rtl/ex_issue_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_ex_issue_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_issue_ctrl.sv
// ex_issue_ctrl
//
// Issue and sequencing controller for the execute stage. It accepts one
// decoded op per cycle from decode over a valid/ready handshake. It drives
// the one-hot unit selects into the EX result register and stalls issue
// while a multi-cycle multiply or an outstanding load is in flight. It also
// produces the writeback valid/tag that line up with the result register
// output, and lets a flush cancel in-flight work.
//
// Ports
//   clk, rst            clock and asynchronous active-high reset
//   issue_valid_i       decode offers an op
//   issue_ready_o       controller can accept an op this cycle
//   issue_op_i [2:0]    0 addsub, 1 mul, 2 shift, 3 logic, 4 ld, 5 br, 6/7 illegal
//   issue_tag_i         destination tag of the offered op
//   ld_ack_i            load data valid this cycle
//   flush_i             cancel in-flight op and pending writeback
//   ctrl_*_o            one-hot unit selects to the result register
//   wb_valid_o          result valid at result register output this cycle
//   wb_tag_o            tag for wb_valid_o, zero when not valid
//   busy_o              controller is not idle
//   illegal_o           one-cycle pulse after an illegal op is accepted

module ex_issue_ctrl #(
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned TAG_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid_i,
    output logic             issue_ready_o,
    input  logic [2:0]       issue_op_i,
    input  logic [TAG_W-1:0] issue_tag_i,
    input  logic             ld_ack_i,
    input  logic             flush_i,
    output logic             ctrl_addsub_o,
    output logic             ctrl_mul_o,
    output logic             ctrl_shift_o,
    output logic             ctrl_logic_o,
    output logic             ctrl_ld_o,
    output logic             ctrl_br_o,
    output logic             wb_valid_o,
    output logic [TAG_W-1:0] wb_tag_o,
    output logic             busy_o,
    output logic             illegal_o
);

    // Counter only has to hold MUL_LAT-1, which always fits in clog2(MUL_LAT) bits.
    localparam int unsigned CNT_W = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [2:0] OP_ADDSUB = 3'd0;
    localparam logic [2:0] OP_MUL    = 3'd1;
    localparam logic [2:0] OP_SHIFT  = 3'd2;
    localparam logic [2:0] OP_LOGIC  = 3'd3;
    localparam logic [2:0] OP_LD     = 3'd4;
    localparam logic [2:0] OP_BR     = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MUL_WAIT = 2'd1,
        S_LD_WAIT  = 2'd2,
        S_LD_DRAIN = 2'd3
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [TAG_W-1:0]   op_tag;     // tag of the outstanding mul or ld
    logic               pend_valid; // writeback presented by the result register this cycle
    logic [TAG_W-1:0]   pend_tag;
    logic               illegal_q;

    logic               accept;
    logic               is_single;
    logic               is_illegal;
    logic               mul_fire;
    logic               ld_fire;
    logic               pend_live;

    // Ready depends on the state register and flush only; rst gating keeps it low during reset.
    always_comb begin
        issue_ready_o = (state == S_IDLE) && !flush_i && !rst;
        busy_o        = (state != S_IDLE);
        illegal_o     = illegal_q;
    end

    // Handshake and op classification.
    always_comb begin
        accept     = issue_valid_i && issue_ready_o;
        is_single  = (issue_op_i == OP_ADDSUB) || (issue_op_i == OP_SHIFT) ||
                     (issue_op_i == OP_LOGIC)  || (issue_op_i == OP_BR);
        is_illegal = (issue_op_i[2:1] == 2'b11);
        mul_fire   = (state == S_MUL_WAIT) && (cnt == CNT_ONE) && !flush_i;
        ld_fire    = (state == S_LD_WAIT) && ld_ack_i && !flush_i;
        pend_live  = pend_valid && !flush_i;
    end

    // Unit selects: single-cycle ops select in the accept cycle, mul one
    // cycle before its writeback, ld in the ack cycle.
    always_comb begin
        ctrl_addsub_o = accept && (issue_op_i == OP_ADDSUB);
        ctrl_shift_o  = accept && (issue_op_i == OP_SHIFT);
        ctrl_logic_o  = accept && (issue_op_i == OP_LOGIC);
        ctrl_br_o     = accept && (issue_op_i == OP_BR);
        ctrl_mul_o    = mul_fire;
        ctrl_ld_o     = ld_fire;
    end

    // Writeback: a load bypasses the result register, everything else is
    // the registered pending entry. The two can never coincide because a
    // load is only accepted from IDLE one cycle after any single-cycle op.
    always_comb begin
        wb_valid_o = 1'b0;
        wb_tag_o   = '0;
        if (ld_fire) begin
            wb_valid_o = 1'b1;
            wb_tag_o   = op_tag;
        end else if (pend_live) begin
            wb_valid_o = 1'b1;
            wb_tag_o   = pend_tag;
        end
    end

    // Sequencing state machine.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            op_tag     <= '0;
            pend_valid <= 1'b0;
            pend_tag   <= '0;
            illegal_q  <= 1'b0;
        end else begin
            // Pending writeback lives for exactly one cycle unless refilled.
            pend_valid <= 1'b0;
            pend_tag   <= '0;
            illegal_q  <= accept && is_illegal;

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (is_single) begin
                            pend_valid <= 1'b1;
                            pend_tag   <= issue_tag_i;
                        end else if (issue_op_i == OP_MUL) begin
                            op_tag <= issue_tag_i;
                            cnt    <= CNT_LOAD;
                            state  <= S_MUL_WAIT;
                        end else if (issue_op_i == OP_LD) begin
                            op_tag <= issue_tag_i;
                            state  <= S_LD_WAIT;
                        end
                    end
                end

                S_MUL_WAIT: begin
                    if (flush_i) begin
                        cnt    <= '0;
                        op_tag <= '0;
                        state  <= S_IDLE;
                    end else if (cnt == CNT_ONE) begin
                        // Result captured this edge; present it next cycle.
                        pend_valid <= 1'b1;
                        pend_tag   <= op_tag;
                        cnt        <= '0;
                        state      <= S_IDLE;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end

                S_LD_WAIT: begin
                    if (ld_ack_i) begin
                        // With flush the ack is consumed silently.
                        op_tag <= '0;
                        state  <= S_IDLE;
                    end else if (flush_i) begin
                        op_tag <= '0;
                        state  <= S_LD_DRAIN;
                    end
                end

                S_LD_DRAIN: begin
                    // Swallow the cancelled load's ack; flush here changes nothing.
                    if (ld_ack_i) begin
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_issue_ctrl.sv
// Bench for ex_issue_ctrl: a directed vector table, a reset-in-flight
// sequence, then random traffic against a timestamp/queue reference model.

module tb_ex_issue_ctrl;

    localparam int unsigned MUL_LAT = 3;
    localparam int unsigned TAG_W   = 5;
    localparam int unsigned OW      = 10 + TAG_W;
    localparam int          N_TBL   = 39;
    localparam int          N_RAND  = 3000;

    typedef logic [OW-1:0] obus_t;  // {ready, busy, illegal, wb_valid, ctrl[5:0], wb_tag}

    typedef struct {
        logic             v;
        logic [2:0]       op;
        logic [TAG_W-1:0] tag;
        logic             ack;
        logic             fl;
        obus_t            exp;
    } vec_t;

    typedef struct {
        int               at;
        logic [TAG_W-1:0] tag;
    } wb_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             issue_valid;
    logic             issue_ready;
    logic [2:0]       issue_op;
    logic [TAG_W-1:0] issue_tag;
    logic             ld_ack;
    logic             flush;
    logic             ctrl_addsub, ctrl_mul, ctrl_shift, ctrl_logic, ctrl_ld, ctrl_br;
    logic             wb_valid;
    logic [TAG_W-1:0] wb_tag;
    logic             busy;
    logic             illegal;

    int n_vec = 0;
    int n_err = 0;

    ex_issue_ctrl #(.MUL_LAT(MUL_LAT), .TAG_W(TAG_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .issue_valid_i (issue_valid),
        .issue_ready_o (issue_ready),
        .issue_op_i    (issue_op),
        .issue_tag_i   (issue_tag),
        .ld_ack_i      (ld_ack),
        .flush_i       (flush),
        .ctrl_addsub_o (ctrl_addsub),
        .ctrl_mul_o    (ctrl_mul),
        .ctrl_shift_o  (ctrl_shift),
        .ctrl_logic_o  (ctrl_logic),
        .ctrl_ld_o     (ctrl_ld),
        .ctrl_br_o     (ctrl_br),
        .wb_valid_o    (wb_valid),
        .wb_tag_o      (wb_tag),
        .busy_o        (busy),
        .illegal_o     (illegal)
    );

    always #5 clk = ~clk;

    function automatic obus_t pack(int rdy, int bsy, int ill, int wbv, int ctrl, int wt);
        return {1'(rdy), 1'(bsy), 1'(ill), 1'(wbv), 6'(ctrl), TAG_W'(wt)};
    endfunction

    function automatic vec_t mk(int v, int op, int tag, int ack, int fl,
                                int rdy, int bsy, int ill, int wbv, int ctrl, int wt);
        vec_t r;
        r.v   = 1'(v);
        r.op  = 3'(op);
        r.tag = TAG_W'(tag);
        r.ack = 1'(ack);
        r.fl  = 1'(fl);
        r.exp = pack(rdy, bsy, ill, wbv, ctrl, wt);
        return r;
    endfunction

    function automatic obus_t dut_out();
        return {issue_ready, busy, illegal, wb_valid,
                ctrl_addsub, ctrl_mul, ctrl_shift, ctrl_logic, ctrl_ld, ctrl_br, wb_tag};
    endfunction

    task automatic check(input string name, input obus_t exp);
        obus_t act;
        act = dut_out();
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got rdy=%b busy=%b ill=%b wbv=%b ctrl=%b tag=%0d, want rdy=%b busy=%b ill=%b wbv=%b ctrl=%b tag=%0d",
                     name, act[OW-1], act[OW-2], act[OW-3], act[OW-4], act[TAG_W+5:TAG_W], act[TAG_W-1:0],
                     exp[OW-1], exp[OW-2], exp[OW-3], exp[OW-4], exp[TAG_W+5:TAG_W], exp[TAG_W-1:0]);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [TAG_W-1:0] tag,
                         input logic ack, input logic fl);
        issue_valid = v;
        issue_op    = op;
        issue_tag   = tag;
        ld_ack      = ack;
        flush       = fl;
    endtask

    // Reference model: absolute cycle timestamps plus a writeback queue.
    int               m_cyc;
    bit               m_mul;
    int               m_mul_end;
    bit               m_ldw;
    bit               m_ldd;
    logic [TAG_W-1:0] m_ld_tag;
    int               m_ill_at;
    wb_t              wbq[$];

    task automatic model_reset();
        m_cyc     = 0;
        m_mul     = 0;
        m_mul_end = 0;
        m_ldw     = 0;
        m_ldd     = 0;
        m_ld_tag  = '0;
        m_ill_at  = -1;
        wbq.delete();
    endtask

    task automatic model_step(input logic v, input logic [2:0] op, input logic [TAG_W-1:0] tag,
                              input logic ack, input logic fl, output obus_t exp);
        bit               bsy, rdy, acc, ld_done, wbv, ill;
        logic [5:0]       ctrl;
        logic [TAG_W-1:0] wt;
        wb_t              e;

        bsy  = m_mul || m_ldw || m_ldd;
        rdy  = !bsy && !fl;
        acc  = v && rdy;
        ctrl = '0;
        if (acc) begin
            case (op)
                3'd0: ctrl[5] = 1'b1;
                3'd2: ctrl[3] = 1'b1;
                3'd3: ctrl[2] = 1'b1;
                3'd5: ctrl[0] = 1'b1;
                default: ;
            endcase
        end
        if (m_mul && (m_cyc == m_mul_end - 1) && !fl) ctrl[4] = 1'b1;
        ld_done = m_ldw && ack && !fl;
        if (ld_done) ctrl[1] = 1'b1;

        wbv = 0;
        wt  = '0;
        if (ld_done) begin
            wbv = 1;
            wt  = m_ld_tag;
        end else if (!fl && wbq.size() > 0 && wbq[0].at == m_cyc) begin
            wbv = 1;
            wt  = wbq[0].tag;
        end
        ill = (m_ill_at == m_cyc);
        exp = {rdy, bsy, ill, wbv, ctrl, wt};

        // advance one cycle
        while (wbq.size() > 0 && wbq[0].at <= m_cyc) void'(wbq.pop_front());
        if (fl) begin
            wbq.delete();
            m_mul = 0;
        end
        if (m_mul && (m_cyc + 1 == m_mul_end)) m_mul = 0;
        if (m_ldd && ack) m_ldd = 0;
        if (m_ldw) begin
            if (ack) m_ldw = 0;
            else if (fl) begin
                m_ldw = 0;
                m_ldd = 1;
            end
        end
        if (acc) begin
            case (op)
                3'd1: begin
                    m_mul     = 1;
                    m_mul_end = m_cyc + int'(MUL_LAT);
                    e.at      = m_mul_end;
                    e.tag     = tag;
                    wbq.push_back(e);
                end
                3'd4: begin
                    m_ldw    = 1;
                    m_ld_tag = tag;
                end
                3'd6, 3'd7: m_ill_at = m_cyc + 1;
                default: begin
                    e.at  = m_cyc + 1;
                    e.tag = tag;
                    wbq.push_back(e);
                end
            endcase
        end
        m_cyc++;
    endtask

    vec_t tbl[N_TBL];

    initial begin
        obus_t            exp;
        logic             rv, rack, rfl;
        logic [2:0]       rop;
        logic [TAG_W-1:0] rtag;

        //           v op tag ack fl   rdy bsy ill wbv ctrl        wt
        tbl[0]  = mk(1, 0,  3, 0, 0,   1, 0, 0, 0, 'b100000,  0);
        tbl[1]  = mk(1, 3,  7, 0, 0,   1, 0, 0, 1, 'b000100,  3);
        tbl[2]  = mk(0, 0,  0, 0, 0,   1, 0, 0, 1, 0,         7);
        tbl[3]  = mk(1, 1,  9, 0, 0,   1, 0, 0, 0, 0,         0);
        tbl[4]  = mk(1, 2, 10, 0, 0,   0, 1, 0, 0, 0,         0);
        tbl[5]  = mk(1, 2, 10, 0, 0,   0, 1, 0, 0, 'b010000,  0);
        tbl[6]  = mk(1, 2, 10, 0, 0,   1, 0, 0, 1, 'b001000,  9);
        tbl[7]  = mk(0, 0,  0, 0, 0,   1, 0, 0, 1, 0,        10);
        tbl[8]  = mk(1, 4, 12, 0, 0,   1, 0, 0, 0, 0,         0);
        tbl[9]  = mk(0, 0,  0, 0, 0,   0, 1, 0, 0, 0,         0);
        tbl[10] = mk(0, 0,  0, 0, 0,   0, 1, 0, 0, 0,         0);
        tbl[11] = mk(0, 0,  0, 0, 0,   0, 1, 0, 0, 0,         0);
        tbl[12] = mk(0, 0,  0, 1, 0,   0, 1, 0, 1, 'b000010, 12);
        tbl[13] = mk(0, 0,  0, 0, 0,   1, 0, 0, 0, 0,         0);
        tbl[14] = mk(0, 0,  0, 0, 0,   1, 0, 0, 0, 0,         0);
        tbl[15] = mk(0, 0,  0, 1, 0,   1, 0, 0, 0, 0,         0);
        tbl[16] = mk(1, 7,  5, 0, 0,   1, 0, 0, 0, 0,         0);
        tbl[17] = mk(0, 0,  0, 0, 0,   1, 0, 1, 0, 0,         0);
        tbl[18] = mk(0, 0,  0, 0, 0,   1, 0, 0, 0, 0,         0);
        tbl[19] = mk(1, 4,  4, 0, 0,   1, 0, 0, 0, 0,         0);
        tbl[20] = mk(0, 0,  0, 0, 0,   0, 1, 0, 0, 0,         0);
        tbl[21] = mk(0, 0,  0, 0, 1,   0, 1, 0, 0, 0,         0);
        tbl[22] = mk(0, 0,  0, 0, 1,   0, 1, 0, 0, 0,         0);
        tbl[23] = mk(0, 0,  0, 0, 0,   0, 1, 0, 0, 0,         0);
        tbl[24] = mk(0, 0,  0, 1, 0,   0, 1, 0, 0, 0,         0);
        tbl[25] = mk(0, 0,  0, 0, 0,   1, 0, 0, 0, 0,         0);
        tbl[26] = mk(1, 1,  2, 0, 0,   1, 0, 0, 0, 0,         0);
        tbl[27] = mk(0, 0,  0, 0, 1,   0, 1, 0, 0, 0,         0);
        tbl[28] = mk(0, 0,  0, 0, 0,   1, 0, 0, 0, 0,         0);
        tbl[29] = mk(1, 0,  6, 0, 0,   1, 0, 0, 0, 'b100000,  0);
        tbl[30] = mk(1, 0,  6, 0, 1,   0, 0, 0, 0, 0,         0);
        tbl[31] = mk(0, 0,  0, 0, 0,   1, 0, 0, 0, 0,         0);
        tbl[32] = mk(1, 4,  8, 0, 0,   1, 0, 0, 0, 0,         0);
        tbl[33] = mk(0, 0,  0, 1, 1,   0, 1, 0, 0, 0,         0);
        tbl[34] = mk(0, 0,  0, 0, 0,   1, 0, 0, 0, 0,         0);
        tbl[35] = mk(1, 5, 11, 0, 0,   1, 0, 0, 0, 'b000001,  0);
        tbl[36] = mk(0, 0,  0, 0, 0,   1, 0, 0, 1, 0,        11);
        tbl[37] = mk(1, 6,  1, 0, 0,   1, 0, 0, 0, 0,         0);
        tbl[38] = mk(0, 0,  0, 0, 0,   1, 0, 1, 0, 0,         0);

        // reset: everything low, even with an op offered
        rst = 1'b1;
        drive(1'b1, 3'd0, TAG_W'(1), 1'b1, 1'b0);
        #2;
        check("reset_hold", pack(0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 3'd0, '0, 1'b0, 1'b0);
        #2;
        check("reset_release", pack(1, 0, 0, 0, 0, 0));

        // directed vector table
        for (int i = 0; i < N_TBL; i++) begin
            @(negedge clk);
            drive(tbl[i].v, tbl[i].op, tbl[i].tag, tbl[i].ack, tbl[i].fl);
            #2;
            check($sformatf("tbl[%0d]", i), tbl[i].exp);
        end

        // reset asserted in the middle of a multiply
        @(negedge clk);
        drive(1'b1, 3'd1, TAG_W'(13), 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 3'd0, '0, 1'b0, 1'b0);
        #2;
        check("mul_wait_busy", pack(0, 1, 0, 0, 0, 0));
        rst = 1'b1;
        #1;
        check("rst_mid_mul", pack(0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < int'(MUL_LAT) + 2; k++) begin
            @(negedge clk);
            drive(1'b0, 3'd0, '0, (k == 1), 1'b0);
            #2;
            check($sformatf("post_rst[%0d]", k), pack(1, 0, 0, 0, 0, 0));
        end

        // random traffic against the reference model
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 3'd0, '0, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < N_RAND; c++) begin
            @(negedge clk);
            rv   = ($urandom_range(0, 99) < 70);
            rop  = ($urandom_range(0, 15) == 0) ? 3'(6 + $urandom_range(0, 1)) : 3'($urandom_range(0, 5));
            rtag = TAG_W'($urandom);
            rack = ($urandom_range(0, 99) < 30);
            rfl  = ($urandom_range(0, 99) < 5);
            drive(rv, rop, rtag, rack, rfl);
            #2;
            model_step(rv, rop, rtag, rack, rfl, exp);
            check($sformatf("rand[%0d]", c), exp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
